// File: rtl/tcb_lib_processor2memory.sv
// tcb_lib_processor2memory
//   Bridges a TCB manager in PROCESSOR mode (LSB-aligned data) to a TCB
//   subordinate in MEMORY mode (data on address-selected byte lanes).
//   Request path is combinational: write data and byte enables are re-laned
//   from the low address bits and the transfer size. Read data is re-aligned
//   with request attributes delayed through a DLY-deep shift pipeline, which
//   matches the subordinate's fixed response latency.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   man_vld/wen/adr/siz/wdt -> man_rdy, man_rdt, man_err   manager side
//   sub_vld/wen/adr/siz/ben/wdt, sub_rdy, sub_rdt, sub_err subordinate side
//
// Build option
//   TCB_MISALIGNED_ERR_EN : misaligned requests (off mod 2**siz != 0) are
//   accepted locally, not forwarded, and answered with an error after DLY
//   cycles. Undefined: misaligned requests are forwarded, lanes past the bus
//   are dropped.

package tcb_p2m_pkg;
  typedef enum logic {TCB_LITTLE = 1'b0, TCB_BIG = 1'b1} tcb_mode_endianness_t;
endpackage

// One byte lane: write-side lane mux (request off/siz) and read-side byte
// mux (response off/siz). Lane index L doubles as the read payload byte index.
module tcb_lib_processor2memory_lane
  import tcb_p2m_pkg::*;
#(
  parameter int                   BEW    = 4,
  parameter int                   L      = 0,
  parameter int                   OFS    = 2,
  parameter int                   SZW    = 2,
  parameter tcb_mode_endianness_t ENDIAN = TCB_LITTLE
)(
  input  logic [OFS-1:0]         i_req_off,
  input  logic [SZW-1:0]         i_req_siz,
  input  logic [BEW-1:0][7:0]    i_wdt,
  input  logic [OFS-1:0]         i_rsp_off,
  input  logic [SZW-1:0]         i_rsp_siz,
  input  logic [BEW-1:0][7:0]    i_rdt,
  output logic                   o_ben,
  output logic [7:0]             o_wdt,
  output logic [7:0]             o_rdt
);
  always_comb begin
    int  off, n, src;
    logic en;
    // write: lane L is enabled when it falls inside off..off+n-1
    off = int'(i_req_off);
    n   = 1 << i_req_siz;
    en  = (L >= off) && (L < off + n);
    src = (ENDIAN == TCB_LITTLE) ? (L - off) : (off + n - 1 - L);
    o_ben = en;
    o_wdt = '0;
    if (en)
      for (int j = 0; j < BEW; j++)
        if (j == src) o_wdt = i_wdt[j];
    // read: payload byte L comes from its lane; lanes past the bus read as 0
    off = int'(i_rsp_off);
    n   = 1 << i_rsp_siz;
    src = (ENDIAN == TCB_LITTLE) ? (off + L) : (off + n - 1 - L);
    o_rdt = '0;
    if (L < n)
      for (int j = 0; j < BEW; j++)
        if (j == src) o_rdt = i_rdt[j];
  end
endmodule

module tcb_lib_processor2memory
  import tcb_p2m_pkg::*;
#(
  parameter int                   ABW    = 32,
  parameter int                   DBW    = 32,
  parameter int                   DLY    = 1,
  parameter tcb_mode_endianness_t ENDIAN = TCB_LITTLE,
  localparam int BEW = DBW / 8,
  localparam int OFW = $clog2(BEW),
  localparam int SZ0 = $clog2($clog2(BEW) + 1),
  localparam int SZW = (SZ0 > 0) ? SZ0 : 1,
  localparam int OFS = (OFW > 0) ? OFW : 1
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           man_vld,
  input  logic           man_wen,
  input  logic [ABW-1:0] man_adr,
  input  logic [SZW-1:0] man_siz,
  input  logic [DBW-1:0] man_wdt,
  output logic           man_rdy,
  output logic [DBW-1:0] man_rdt,
  output logic           man_err,
  output logic           sub_vld,
  output logic           sub_wen,
  output logic [ABW-1:0] sub_adr,
  output logic [SZW-1:0] sub_siz,
  output logic [BEW-1:0] sub_ben,
  output logic [DBW-1:0] sub_wdt,
  input  logic           sub_rdy,
  input  logic [DBW-1:0] sub_rdt,
  input  logic           sub_err
);
  typedef struct packed {
    logic           vld;
    logic           wen;
    logic [OFS-1:0] off;
    logic [SZW-1:0] siz;
    logic           inj;
  } stg_t;

  logic [OFS-1:0]      w_off;
  logic                w_inj;
  stg_t                w_req, w_rsp;
  logic [BEW-1:0][7:0] w_wdt_in, w_wdt_out, w_rdt_in, w_rdt_out;

  // a byte-wide bus has no offset bits
  assign w_off = (OFW > 0) ? man_adr[OFS-1:0] : '0;

`ifdef TCB_MISALIGNED_ERR_EN
  logic w_mis;
  assign w_mis = (int'(w_off) & ((1 << man_siz) - 1)) != 0;
  assign w_inj = w_mis;
`else
  assign w_inj = 1'b0;
`endif

  // misaligned requests (when checked) are swallowed and acknowledged here
  assign sub_vld = man_vld & ~w_inj;
  assign man_rdy = w_inj | sub_rdy;
  assign sub_wen = man_wen;
  assign sub_adr = man_adr;
  assign sub_siz = man_siz;

  assign w_req = '{vld: man_vld & man_rdy, wen: man_wen, off: w_off,
                   siz: man_siz, inj: w_inj};

  // Response timing is fixed, so the attribute pipe shifts every cycle.
  generate
    if (DLY == 0) begin : g_comb
      assign w_rsp = w_req;
    end else begin : g_pipe
      stg_t r_pipe [DLY];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DLY; k++) r_pipe[k] <= '0;
        end else begin
          r_pipe[0] <= w_req;
          for (int k = 1; k < DLY; k++) r_pipe[k] <= r_pipe[k-1];
        end
      end
      assign w_rsp = r_pipe[DLY-1];
    end
  endgenerate

  assign w_wdt_in = man_wdt;
  assign w_rdt_in = sub_rdt;

  generate
    for (genvar l = 0; l < BEW; l++) begin : g_lane
      tcb_lib_processor2memory_lane #(
        .BEW(BEW), .L(l), .OFS(OFS), .SZW(SZW), .ENDIAN(ENDIAN)
      ) u_lane (
        .i_req_off (w_off),
        .i_req_siz (man_siz),
        .i_wdt     (w_wdt_in),
        .i_rsp_off (w_rsp.off),
        .i_rsp_siz (w_rsp.siz),
        .i_rdt     (w_rdt_in),
        .o_ben     (sub_ben[l]),
        .o_wdt     (w_wdt_out[l]),
        .o_rdt     (w_rdt_out[l])
      );
    end
  endgenerate

  assign sub_wdt = w_wdt_out;
  // injected errors never return data, writes never return data
  assign man_rdt = (w_rsp.vld & ~w_rsp.wen & ~w_rsp.inj) ? w_rdt_out : '0;
  assign man_err = w_rsp.vld & (sub_err | w_rsp.inj);
endmodule

// File: tb/tb_tcb_lib_processor2memory.sv
// Directed bench: three DUTs share one stimulus set.
//   u0: DLY=1 little, u1: DLY=1 big, u2: DLY=2 little.
module tb_tcb_lib_processor2memory;
  import tcb_p2m_pkg::*;

`ifdef TCB_MISALIGNED_ERR_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        man_vld = 1'b0, man_wen = 1'b0;
  logic [31:0] man_adr = '0, man_wdt = '0;
  logic [1:0]  man_siz = '0;
  logic        sub_rdy = 1'b1, sub_err = 1'b0;
  logic [31:0] sub_rdt = '0;

  logic        man_rdy [3];
  logic [31:0] man_rdt [3];
  logic        man_err [3];
  logic        sub_vld [3];
  logic        sub_wen [3];
  logic [31:0] sub_adr [3];
  logic [1:0]  sub_siz [3];
  logic [3:0]  sub_ben [3];
  logic [31:0] sub_wdt [3];

  always #5 clk = ~clk;

  tcb_lib_processor2memory #(.DLY(1), .ENDIAN(TCB_LITTLE)) u0 (
    .clk(clk), .rst(rst), .man_vld(man_vld), .man_wen(man_wen), .man_adr(man_adr),
    .man_siz(man_siz), .man_wdt(man_wdt), .man_rdy(man_rdy[0]), .man_rdt(man_rdt[0]),
    .man_err(man_err[0]), .sub_vld(sub_vld[0]), .sub_wen(sub_wen[0]), .sub_adr(sub_adr[0]),
    .sub_siz(sub_siz[0]), .sub_ben(sub_ben[0]), .sub_wdt(sub_wdt[0]), .sub_rdy(sub_rdy),
    .sub_rdt(sub_rdt), .sub_err(sub_err));

  tcb_lib_processor2memory #(.DLY(1), .ENDIAN(TCB_BIG)) u1 (
    .clk(clk), .rst(rst), .man_vld(man_vld), .man_wen(man_wen), .man_adr(man_adr),
    .man_siz(man_siz), .man_wdt(man_wdt), .man_rdy(man_rdy[1]), .man_rdt(man_rdt[1]),
    .man_err(man_err[1]), .sub_vld(sub_vld[1]), .sub_wen(sub_wen[1]), .sub_adr(sub_adr[1]),
    .sub_siz(sub_siz[1]), .sub_ben(sub_ben[1]), .sub_wdt(sub_wdt[1]), .sub_rdy(sub_rdy),
    .sub_rdt(sub_rdt), .sub_err(sub_err));

  tcb_lib_processor2memory #(.DLY(2), .ENDIAN(TCB_LITTLE)) u2 (
    .clk(clk), .rst(rst), .man_vld(man_vld), .man_wen(man_wen), .man_adr(man_adr),
    .man_siz(man_siz), .man_wdt(man_wdt), .man_rdy(man_rdy[2]), .man_rdt(man_rdt[2]),
    .man_err(man_err[2]), .sub_vld(sub_vld[2]), .sub_wen(sub_wen[2]), .sub_adr(sub_adr[2]),
    .sub_siz(sub_siz[2]), .sub_ben(sub_ben[2]), .sub_wdt(sub_wdt[2]), .sub_rdy(sub_rdy),
    .sub_rdt(sub_rdt), .sub_err(sub_err));

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] adr;
    logic [1:0]  siz;
    logic [31:0] wdt;
    logic        mis;
    logic [3:0]  ben;
    logic [31:0] le;
    logic        chk_be;
    logic [31:0] be;
  } req_vec_t;

  typedef struct {
    logic [31:0] adr;
    logic [1:0]  siz;
    logic        mis;
    logic [31:0] rdt;
    logic        err;
    logic [31:0] le;
    logic [31:0] be;
  } rd_vec_t;

  req_vec_t rq [8];
  rd_vec_t  rd [6];

  initial begin
    logic        exp_vld, exp_rdy, swallow;
    logic [31:0] r2_adr [3];
    logic [1:0]  r2_siz [3];
    logic [31:0] r2_rdt [3];
    logic        r2_err [3];
    logic [31:0] r2_exp [3];

    rq[0] = '{1'b1, 32'h102, 2'd1, 32'h0000BEEF, 1'b0, 4'b1100, 32'hBEEF0000, 1'b1, 32'hEFBE0000};
    rq[1] = '{1'b1, 32'h100, 2'd2, 32'h11223344, 1'b0, 4'b1111, 32'h11223344, 1'b1, 32'h44332211};
    rq[2] = '{1'b1, 32'h103, 2'd0, 32'hFFFFFF5A, 1'b0, 4'b1000, 32'h5A000000, 1'b1, 32'h5A000000};
    rq[3] = '{1'b0, 32'h101, 2'd0, 32'h00000077, 1'b0, 4'b0010, 32'h00007700, 1'b1, 32'h00007700};
    rq[4] = '{1'b1, 32'h100, 2'd1, 32'hAABBCCDD, 1'b0, 4'b0011, 32'h0000CCDD, 1'b1, 32'h0000DDCC};
    rq[5] = '{1'b1, 32'h200, 2'd3, 32'h01020304, 1'b0, 4'b1111, 32'h01020304, 1'b0, 32'h0};
    rq[6] = '{1'b0, 32'h101, 2'd2, 32'h11223344, 1'b1, 4'b1110, 32'h22334400, 1'b1, 32'h33221100};
    rq[7] = '{1'b1, 32'h103, 2'd1, 32'hAABBCCDD, 1'b1, 4'b1000, 32'hDD000000, 1'b1, 32'hCC000000};

    rd[0] = '{32'h103, 2'd0, 1'b0, 32'hA5000000, 1'b0, 32'h000000A5, 32'h000000A5};
    rd[1] = '{32'h100, 2'd2, 1'b0, 32'h11223344, 1'b1, 32'h11223344, 32'h44332211};
    rd[2] = '{32'h102, 2'd1, 1'b0, 32'hBEEF1234, 1'b0, 32'h0000BEEF, 32'h0000EFBE};
    rd[3] = '{32'h101, 2'd0, 1'b0, 32'h12345678, 1'b0, 32'h00000056, 32'h00000056};
    rd[4] = '{32'h100, 2'd1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0000BEEF, 32'h0000EFBE};
    rd[5] = '{32'h101, 2'd2, 1'b1, 32'h11223344, 1'b0, 32'h00112233, 32'h33221100};

    // reset state: responses quiet even with a noisy subordinate
    tick();
    sub_rdt = 32'hFFFFFFFF;
    sub_err = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_rdt%0d", d), man_rdt[d], 32'h0);
      chk($sformatf("rst_err%0d", d), {31'b0, man_err[d]}, 32'h0);
    end
    tick();
    rst = 1'b0;
    sub_err = 1'b0;

    // request path, combinational
    for (int i = 0; i < 8; i++) begin
      man_vld = 1'b1; man_wen = rq[i].wen; man_adr = rq[i].adr;
      man_siz = rq[i].siz; man_wdt = rq[i].wdt;
      sub_rdy = ~rq[i].mis;
      #1;
      swallow = MIS_EN && rq[i].mis;
      exp_vld = ~swallow;
      exp_rdy = swallow | ~rq[i].mis;
      chk($sformatf("req%0d_vld", i), {31'b0, sub_vld[0]}, {31'b0, exp_vld});
      chk($sformatf("req%0d_rdy", i), {31'b0, man_rdy[0]}, {31'b0, exp_rdy});
      chk($sformatf("req%0d_adr", i), sub_adr[0], rq[i].adr);
      chk($sformatf("req%0d_siz_wen", i), {29'b0, sub_wen[0], sub_siz[0]}, {29'b0, rq[i].wen, rq[i].siz});
      if (!swallow) begin
        chk($sformatf("req%0d_ben_le", i), {28'b0, sub_ben[0]}, {28'b0, rq[i].ben});
        chk($sformatf("req%0d_wdt_le", i), sub_wdt[0], rq[i].le);
        if (rq[i].chk_be) begin
          chk($sformatf("req%0d_ben_be", i), {28'b0, sub_ben[1]}, {28'b0, rq[i].ben});
          chk($sformatf("req%0d_wdt_be", i), sub_wdt[1], rq[i].be);
        end
      end
      tick();
    end
    man_vld = 1'b0;
    sub_rdy = 1'b1;
    tick();

    // reads with DLY=1, each followed by its response cycle
    for (int i = 0; i < 6; i++) begin
      man_vld = 1'b1; man_wen = 1'b0; man_adr = rd[i].adr; man_siz = rd[i].siz;
      sub_rdt = 32'hFFFFFFFF; sub_err = 1'b1;
      #1;
      chk($sformatf("rd%0d_idle_rdt", i), man_rdt[0], 32'h0);
      chk($sformatf("rd%0d_idle_err", i), {31'b0, man_err[0]}, 32'h0);
      tick();
      man_vld = 1'b0; sub_rdt = rd[i].rdt; sub_err = rd[i].err;
      #1;
      swallow = MIS_EN && rd[i].mis;
      chk($sformatf("rd%0d_rdt_le", i), man_rdt[0], swallow ? 32'h0 : rd[i].le);
      chk($sformatf("rd%0d_rdt_be", i), man_rdt[1], swallow ? 32'h0 : rd[i].be);
      chk($sformatf("rd%0d_err", i), {31'b0, man_err[0]}, {31'b0, swallow | rd[i].err});
      tick();
    end

    // write response returns no data but does pass the error
    man_vld = 1'b1; man_wen = 1'b1; man_adr = 32'h100; man_siz = 2'd2; man_wdt = 32'h5555AAAA;
    tick();
    man_vld = 1'b0; sub_rdt = 32'hFFFFFFFF; sub_err = 1'b1;
    #1;
    chk("wr_rsp_rdt", man_rdt[0], 32'h0);
    chk("wr_rsp_err", {31'b0, man_err[0]}, 32'h1);
    tick();

    // stalled request: no transfer, so no response
    man_vld = 1'b1; man_wen = 1'b0; man_adr = 32'h100; man_siz = 2'd2; sub_rdy = 1'b0;
    #1;
    chk("stall_rdy", {31'b0, man_rdy[0]}, 32'h0);
    tick();
    man_vld = 1'b0; sub_rdy = 1'b1;
    #1;
    chk("stall_rsp_err", {31'b0, man_err[0]}, 32'h0);
    chk("stall_rsp_rdt", man_rdt[0], 32'h0);
    tick();

    // DLY=2 back-to-back reads, error only on the second
    r2_adr = '{32'h101, 32'h102, 32'h100};
    r2_siz = '{2'd0, 2'd1, 2'd2};
    r2_rdt = '{32'h0000AB00, 32'hCDEF0000, 32'h01234567};
    r2_err = '{1'b0, 1'b1, 1'b0};
    r2_exp = '{32'h000000AB, 32'h0000CDEF, 32'h01234567};
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        man_vld = 1'b1; man_wen = 1'b0; man_adr = r2_adr[k]; man_siz = r2_siz[k];
      end else begin
        man_vld = 1'b0;
      end
      if (k >= 2) begin
        sub_rdt = r2_rdt[k-2]; sub_err = r2_err[k-2];
      end else begin
        sub_rdt = 32'hFFFFFFFF; sub_err = 1'b1;
      end
      #1;
      if (k >= 2) begin
        chk($sformatf("d2_rdt%0d", k-2), man_rdt[2], r2_exp[k-2]);
        chk($sformatf("d2_err%0d", k-2), {31'b0, man_err[2]}, {31'b0, r2_err[k-2]});
      end else begin
        chk($sformatf("d2_pre_rdt%0d", k), man_rdt[2], 32'h0);
        chk($sformatf("d2_pre_err%0d", k), {31'b0, man_err[2]}, 32'h0);
      end
      tick();
    end

    // reset with two DLY=2 reads outstanding
    man_vld = 1'b1; man_wen = 1'b0; man_adr = 32'h100; man_siz = 2'd2;
    tick();
    man_adr = 32'h101; man_siz = 2'd0;
    tick();
    man_vld = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    sub_rdt = 32'hFFFFFFFF; sub_err = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("mid_rst_rdt%0d", k), man_rdt[2], 32'h0);
      chk($sformatf("mid_rst_err%0d", k), {31'b0, man_err[2]}, 32'h0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
